// File: rtl/cq_pkg.sv
// Shared helpers for the multi-port circular queue.
// Pointer arithmetic wraps by one conditional subtract, so L need not be a power of two.
package cq_pkg;

    function automatic int cq_wrap_add(input int ptr, input int n, input int l);
        int s;
        s = ptr + n;
        return (s >= l) ? s - l : s;
    endfunction

endpackage

// File: rtl/cq_ptr_adv.sv
// Combinational modular pointer advance: o_ptr = (i_ptr + i_n) mod L, with i_ptr < L and i_n <= L.
module cq_ptr_adv
    import cq_pkg::*;
#(
    parameter int L  = 16,
    parameter int PW = $clog2(L),
    parameter int NW = $clog2(L + 1)
) (
    input  logic [PW-1:0] i_ptr,
    input  logic [NW-1:0] i_n,
    output logic [PW-1:0] o_ptr
);

    assign o_ptr = PW'(cq_wrap_add(int'(i_ptr), int'(i_n), L));

endmodule

// File: rtl/multi_port_circular_queue.sv
// In-order circular queue accepting up to PUSH_W and releasing up to POP_W entries per cycle,
// with all-or-nothing push/pop and a single-cycle flush.
module multi_port_circular_queue
    import cq_pkg::*;
#(
    parameter type T      = logic [31:0],
    parameter int  L      = 16,
    parameter int  PUSH_W = 2,
    parameter int  POP_W  = 2
) (
    input  logic                        clk,
    input  logic                        n_rst,
    input  logic                        i_flush,
    input  logic [$clog2(PUSH_W+1)-1:0] i_push_cnt,
    input  T                            i_in [PUSH_W],
    output logic                        o_push_ok,
    input  logic [$clog2(POP_W+1)-1:0]  i_pop_cnt,
    output logic                        o_pop_ok,
    output T                            o_out [POP_W],
    output logic [POP_W-1:0]            o_out_valid,
    output logic [$clog2(L+1)-1:0]      o_count,
    output logic [$clog2(L+1)-1:0]      o_free,
    output logic                        o_full,
    output logic                        o_empty
);

    localparam int PW = $clog2(L);
    localparam int CW = $clog2(L + 1);

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    T     r_mem [L];
    ptr_t r_head;
    ptr_t r_tail;
    cnt_t r_count;

    ptr_t w_head_nxt;
    ptr_t w_tail_nxt;
    cnt_t w_count_nxt;
    ptr_t w_wr_idx [PUSH_W];
    ptr_t w_rd_idx [POP_W];

    cq_ptr_adv #(.L(L), .PW(PW), .NW(CW)) u_tail_adv (
        .i_ptr (r_tail),
        .i_n   (CW'(i_push_cnt)),
        .o_ptr (w_tail_nxt)
    );

    cq_ptr_adv #(.L(L), .PW(PW), .NW(CW)) u_head_adv (
        .i_ptr (r_head),
        .i_n   (CW'(i_pop_cnt)),
        .o_ptr (w_head_nxt)
    );

    for (genvar k = 0; k < PUSH_W; k++) begin : g_wr_lane
        cq_ptr_adv #(.L(L), .PW(PW), .NW(CW)) u_wr_adv (
            .i_ptr (r_tail),
            .i_n   (CW'(k)),
            .o_ptr (w_wr_idx[k])
        );
    end

    for (genvar i = 0; i < POP_W; i++) begin : g_rd_lane
        cq_ptr_adv #(.L(L), .PW(PW), .NW(CW)) u_rd_adv (
            .i_ptr (r_head),
            .i_n   (CW'(i)),
            .o_ptr (w_rd_idx[i])
        );
    end

    // Acceptance uses start-of-cycle state only; a same-cycle pop never makes room for a push.
    assign o_count   = r_count;
    assign o_free    = cnt_t'(L) - r_count;
    assign o_full    = (r_count == cnt_t'(L));
    assign o_empty   = (r_count == '0);
    assign o_push_ok = !i_flush && (int'(i_push_cnt) <= int'(o_free));
    assign o_pop_ok  = !i_flush && (int'(i_pop_cnt) <= int'(r_count));

    assign w_count_nxt = cnt_t'(int'(r_count)
                                + (o_push_ok ? int'(i_push_cnt) : 0)
                                - (o_pop_ok  ? int'(i_pop_cnt)  : 0));

    always_comb begin
        for (int i = 0; i < POP_W; i++) begin
            o_out_valid[i] = (i < int'(r_count));
            o_out[i]       = o_out_valid[i] ? r_mem[w_rd_idx[i]] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst || i_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (o_push_ok) r_tail <= w_tail_nxt;
            if (o_pop_ok)  r_head <= w_head_nxt;
            r_count <= w_count_nxt;
        end
    end

    // Lane indices within one accepted push are distinct because push_cnt never exceeds free.
    always_ff @(posedge clk) begin
        if (n_rst && o_push_ok) begin
            for (int k = 0; k < PUSH_W; k++) begin
                if (k < int'(i_push_cnt)) r_mem[w_wr_idx[k]] <= i_in[k];
            end
        end
    end

endmodule

// File: tb/tb_multi_port_circular_queue.sv
// Directed bench for the multi-port circular queue at L=5, two push and two pop lanes, 8-bit entries.
module tb_multi_port_circular_queue;

    typedef logic [7:0] byte_t;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        flush;
    logic [1:0]  push_cnt;
    byte_t       in_l [2];
    logic        push_ok;
    logic [1:0]  pop_cnt;
    logic        pop_ok;
    byte_t       out_l [2];
    logic [1:0]  out_valid;
    logic [2:0]  count;
    logic [2:0]  free;
    logic        full;
    logic        empty;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    multi_port_circular_queue #(
        .T(byte_t), .L(5), .PUSH_W(2), .POP_W(2)
    ) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .i_flush     (flush),
        .i_push_cnt  (push_cnt),
        .i_in        (in_l),
        .o_push_ok   (push_ok),
        .i_pop_cnt   (pop_cnt),
        .o_pop_ok    (pop_ok),
        .o_out       (out_l),
        .o_out_valid (out_valid),
        .o_count     (count),
        .o_free      (free),
        .o_full      (full),
        .o_empty     (empty)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change just after the falling edge; comb outputs settle before the rising edge.
    task automatic drive(input logic f, input logic [1:0] pc, input byte_t a, input byte_t b,
                         input logic [1:0] qc);
        flush    = f;
        push_cnt = pc;
        in_l[0]  = a;
        in_l[1]  = b;
        pop_cnt  = qc;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        drive(1'b0, 2'd0, 8'h00, 8'h00, 2'd0);
    endtask

    task automatic check_head(input string tag, input logic [2:0] c, input logic [1:0] v,
                              input byte_t o0, input byte_t o1);
        check({tag, ".count"}, 32'(count), 32'(c));
        check({tag, ".valid"}, 32'(out_valid), 32'(v));
        check({tag, ".out0"}, 32'(out_l[0]), 32'(o0));
        check({tag, ".out1"}, 32'(out_l[1]), 32'(o1));
    endtask

    initial begin
        n_rst = 1'b0;
        idle();
        tick();
        tick();
        n_rst = 1'b1;
        tick();

        // 1: reset state
        check("rst.empty", 32'(empty), 32'd1);
        check("rst.full", 32'(full), 32'd0);
        check("rst.free", 32'(free), 32'd5);
        check_head("rst", 3'd0, 2'b00, 8'h00, 8'h00);

        // 2: two-lane push, one-lane push, two-lane pop
        drive(1'b0, 2'd2, 8'hA1, 8'hB2, 2'd0);
        check("p2.push_ok", 32'(push_ok), 32'd1);
        check("p2.no_bypass", 32'(out_valid), 32'd0);
        tick();
        drive(1'b0, 2'd1, 8'hC3, 8'h99, 2'd0);
        tick();
        idle();
        check_head("p3", 3'd3, 2'b11, 8'hA1, 8'hB2);
        drive(1'b0, 2'd0, 8'h00, 8'h00, 2'd2);
        check("pop2.pop_ok", 32'(pop_ok), 32'd1);
        tick();
        idle();
        check_head("pop2", 3'd1, 2'b01, 8'hC3, 8'h00);

        // 3: fill to full, then push+pop together
        drive(1'b0, 2'd2, 8'h11, 8'h12, 2'd0);
        tick();
        drive(1'b0, 2'd2, 8'h13, 8'h14, 2'd0);
        tick();
        idle();
        check("full.full", 32'(full), 32'd1);
        check("full.free", 32'(free), 32'd0);
        check("full.count", 32'(count), 32'd5);
        drive(1'b0, 2'd1, 8'h15, 8'h00, 2'd1);
        check("full.push_ok", 32'(push_ok), 32'd0);
        check("full.pop_ok", 32'(pop_ok), 32'd1);
        tick();
        idle();
        check_head("full_pp", 3'd4, 2'b11, 8'h11, 8'h12);
        check("full_pp.full", 32'(full), 32'd0);
        drive(1'b0, 2'd0, 8'h00, 8'h00, 2'd2);
        tick();
        idle();
        check_head("drain1", 3'd2, 2'b11, 8'h13, 8'h14);
        drive(1'b0, 2'd0, 8'h00, 8'h00, 2'd2);
        tick();
        idle();
        check("drain2.empty", 32'(empty), 32'd1);

        // 4: steady-state 2-in/2-out stream across many wraps
        drive(1'b0, 2'd2, 8'h40, 8'h41, 2'd0);
        tick();
        for (int j = 0; j < 12; j++) begin
            drive(1'b0, 2'd2, byte_t'(8'h42 + 2*j), byte_t'(8'h43 + 2*j), 2'd2);
            check("wrap.push_ok", 32'(push_ok), 32'd1);
            check("wrap.pop_ok", 32'(pop_ok), 32'd1);
            check("wrap.out0", 32'(out_l[0]), 32'(8'h40 + 2*j));
            check("wrap.out1", 32'(out_l[1]), 32'(8'h41 + 2*j));
            tick();
        end
        idle();
        check_head("wrap_end", 3'd2, 2'b11, 8'h58, 8'h59);
        drive(1'b0, 2'd0, 8'h00, 8'h00, 2'd2);
        tick();
        idle();
        check("wrap_drain.empty", 32'(empty), 32'd1);

        // 5: over-pop rejected, exact pop accepted
        drive(1'b0, 2'd1, 8'h77, 8'h00, 2'd0);
        tick();
        drive(1'b0, 2'd0, 8'h00, 8'h00, 2'd2);
        check("overpop.pop_ok", 32'(pop_ok), 32'd0);
        tick();
        idle();
        check_head("overpop", 3'd1, 2'b01, 8'h77, 8'h00);
        drive(1'b0, 2'd0, 8'h00, 8'h00, 2'd1);
        check("pop1.pop_ok", 32'(pop_ok), 32'd1);
        tick();
        idle();
        check("pop1.empty", 32'(empty), 32'd1);
        drive(1'b0, 2'd0, 8'h00, 8'h00, 2'd1);
        check("emptypop.pop_ok", 32'(pop_ok), 32'd0);
        tick();
        idle();
        check("emptypop.count", 32'(count), 32'd0);

        // 6a: flush with concurrent push
        drive(1'b0, 2'd2, 8'h01, 8'h02, 2'd0);
        tick();
        drive(1'b0, 2'd1, 8'h03, 8'h00, 2'd0);
        tick();
        drive(1'b1, 2'd2, 8'hE1, 8'hE2, 2'd1);
        check("flush.push_ok", 32'(push_ok), 32'd0);
        check("flush.pop_ok", 32'(pop_ok), 32'd0);
        tick();
        idle();
        check_head("flush", 3'd0, 2'b00, 8'h00, 8'h00);
        drive(1'b0, 2'd1, 8'hD0, 8'h00, 2'd0);
        tick();
        idle();
        check_head("flush_d", 3'd1, 2'b01, 8'hD0, 8'h00);

        // 6b: same sequence with reset mid-fill
        drive(1'b0, 2'd2, 8'h04, 8'h05, 2'd0);
        tick();
        drive(1'b0, 2'd1, 8'h06, 8'h00, 2'd0);
        tick();
        n_rst = 1'b0;
        drive(1'b0, 2'd2, 8'hF1, 8'hF2, 2'd0);
        tick();
        n_rst = 1'b1;
        idle();
        check_head("reset", 3'd0, 2'b00, 8'h00, 8'h00);
        check("reset.free", 32'(free), 32'd5);
        drive(1'b0, 2'd1, 8'hD1, 8'h00, 2'd0);
        tick();
        idle();
        check_head("reset_d", 3'd1, 2'b01, 8'hD1, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
